opt_rand_gen: RTL and testbench

- Parametrised random move generator for one replica of the annealing/replica-exchange salesman engine.
- Holds its own xorshift64 state. On each start it draws tour indices by rejection sampling:
  - 2-opt mode: K<L.
  - or-opt mode: K<L<M.
  - Either mode: indices then followed by a Metropolis random and an exchange random.
- Results go to the replica's move/evaluate stage. A saturating draw counter is provided for RNG-efficiency statistics.

---
 rtl/opt_rand_gen.sv | 190 +++++++++++++++++++
 tb/tb_opt_rand_gen.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/opt_rand_gen.sv
`default_nettype none
// ============================================================================
// Module   : opt_rand_gen
// Purpose  : Random move generator for one annealing / replica-exchange
//            salesman replica. A private xorshift64 stream produces tour
//            indices by rejection sampling (2-opt: K<L, or-opt: K<L<M),
//            then a Metropolis random and an exchange random.
// Ports    : clk, reset (sync, active-high)
//            seed_i / seed_load / seed_o : stream seeding and observation
//            base_id_i, start, mode      : move request
//            busy, done, valid           : handshake / result status
//            mode_o, base_id_o           : request fields captured at start
//            k_o, l_o, m_o               : sorted tour indices
//            r_metropolis, r_exchange    : acceptance / exchange randoms
//            draw_cnt                    : saturating count of RNG steps
// Revision : 1.0 - initial release
// ============================================================================
module opt_rand_gen #(
    parameter int CITY_NUM = 30,
    parameter int IDX_W    = $clog2(CITY_NUM + 1),
    parameter int R_W      = 32,
    parameter int BASE_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [63:0]       seed_i,
    input  logic              seed_load,
    output logic [63:0]       seed_o,
    input  logic [BASE_W-1:0] base_id_i,
    input  logic              start,
    input  logic [1:0]        mode,
    output logic              busy,
    output logic              done,
    output logic              valid,
    output logic [1:0]        mode_o,
    output logic [BASE_W-1:0] base_id_o,
    output logic [IDX_W-1:0]  k_o,
    output logic [IDX_W-1:0]  l_o,
    output logic [IDX_W-1:0]  m_o,
    output logic [R_W-1:0]    r_metropolis,
    output logic [R_W-1:0]    r_exchange,
    output logic [15:0]       draw_cnt
);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_DRAW_K  = 3'd1;
    localparam logic [2:0] c_DRAW_L  = 3'd2;
    localparam logic [2:0] c_DRAW_M  = 3'd3;
    localparam logic [2:0] c_DRAW_RM = 3'd4;
    localparam logic [2:0] c_DRAW_RX = 3'd5;

    localparam logic [IDX_W-1:0] c_CITY_MAX = IDX_W'(CITY_NUM);

    logic [63:0]       r_state;
    logic [2:0]        r_fsm;
    logic              r_done;
    logic              r_valid;
    logic [1:0]        r_mode;
    logic [BASE_W-1:0] r_base;
    logic [IDX_W-1:0]  r_k;
    logic [IDX_W-1:0]  r_l;
    logic [IDX_W-1:0]  r_m;
    logic [R_W-1:0]    r_rm;
    logic [R_W-1:0]    r_rx;
    logic [15:0]       r_cnt;

    logic [63:0]       w_x1;
    logic [63:0]       w_x2;
    logic [63:0]       w_nx;
    logic [IDX_W-1:0]  w_cand;
    logic [R_W-1:0]    w_rv;
    logic              w_in_range;
    logic [63:0]       w_seed_fix;

    // xorshift64 (13, 7, 17) step of the current state
    assign w_x1   = r_state ^ (r_state << 13);
    assign w_x2   = w_x1 ^ (w_x1 >> 7);
    assign w_nx   = w_x2 ^ (w_x2 << 17);
    assign w_cand = w_nx[IDX_W-1:0];
    assign w_rv   = w_nx[R_W-1:0];

    // Index 0 and values past CITY_NUM are rejected; the mask is wider
    // than the legal range whenever CITY_NUM+1 is not a power of two.
    assign w_in_range = (w_cand != '0) && (w_cand <= c_CITY_MAX);

    // xorshift has a fixed point at zero, so a zero seed is replaced by 1
    assign w_seed_fix = (seed_i == 64'h0) ? 64'h1 : seed_i;

    always_ff @(posedge clk) begin
        if (reset || seed_load) begin
            r_state <= w_seed_fix;
            r_fsm   <= c_IDLE;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            // A plain seed_load keeps the last results visible
            if (reset) begin
                r_mode <= 2'b00;
                r_base <= base_id_i;
                r_k    <= '0;
                r_l    <= '0;
                r_m    <= '0;
                r_rm   <= '0;
                r_rx   <= '0;
                r_cnt  <= 16'h0;
            end
        end else begin
            r_done <= 1'b0;

            if (r_fsm != c_IDLE) begin
                r_state <= w_nx;
                if (r_cnt != 16'hFFFF) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end

            case (r_fsm)
                c_IDLE: begin
                    if (start) begin
                        r_mode  <= mode;
                        r_base  <= base_id_i;
                        r_valid <= 1'b0;
                        // modes 10 and 11 both skip index generation
                        r_fsm   <= mode[1] ? c_DRAW_RM : c_DRAW_K;
                    end
                end
                c_DRAW_K: begin
                    if (w_in_range) begin
                        r_k   <= w_cand;
                        r_fsm <= c_DRAW_L;
                    end
                end
                c_DRAW_L: begin
                    if (w_in_range && (w_cand != r_k)) begin
                        if (w_cand < r_k) begin
                            r_k <= w_cand;
                            r_l <= r_k;
                        end else begin
                            r_l <= w_cand;
                        end
                        // only 2-opt (00) and or-opt (01) reach this state
                        r_fsm <= r_mode[0] ? c_DRAW_M : c_DRAW_RM;
                    end
                end
                c_DRAW_M: begin
                    if (w_in_range && (w_cand != r_k) && (w_cand != r_l)) begin
                        if (w_cand < r_k) begin
                            r_k <= w_cand;
                            r_l <= r_k;
                            r_m <= r_l;
                        end else if (w_cand < r_l) begin
                            r_l <= w_cand;
                            r_m <= r_l;
                        end else begin
                            r_m <= w_cand;
                        end
                        r_fsm <= c_DRAW_RM;
                    end
                end
                c_DRAW_RM: begin
                    r_rm  <= w_rv;
                    r_fsm <= c_DRAW_RX;
                end
                c_DRAW_RX: begin
                    r_rx    <= w_rv;
                    r_done  <= 1'b1;
                    r_valid <= 1'b1;
                    r_fsm   <= c_IDLE;
                end
                default: begin
                    r_fsm <= c_IDLE;
                end
            endcase
        end
    end

    assign seed_o       = r_state;
    assign busy         = (r_fsm != c_IDLE);
    assign done         = r_done;
    assign valid        = r_valid;
    assign mode_o       = r_mode;
    assign base_id_o    = r_base;
    assign k_o          = r_k;
    assign l_o          = r_l;
    assign m_o          = r_m;
    assign r_metropolis = r_rm;
    assign r_exchange   = r_rx;
    assign draw_cnt     = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_opt_rand_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_opt_rand_gen
// Purpose  : Self-checking bench for opt_rand_gen. A CITY_NUM=30 instance is
//            driven with directed requests and compared against a sequence
//            model; a CITY_NUM=3 or-opt instance runs back-to-back in
//            parallel to show forced 1/2/3 results and draw_cnt saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_opt_rand_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] seed_i;
    logic        seed_load;
    logic [4:0]  base_id_i;
    logic        start;
    logic [1:0]  mode;

    logic [63:0] seed_o;
    logic        busy, done, valid;
    logic [1:0]  mode_o;
    logic [4:0]  base_id_o;
    logic [4:0]  k_o, l_o, m_o;
    logic [31:0] r_metropolis, r_exchange;
    logic [15:0] draw_cnt;

    // small instance: CITY_NUM=3, start held high
    logic [63:0] s_seed_i;
    logic        s_seed_load;
    logic [4:0]  s_base_i;
    logic        s_start;
    logic [1:0]  s_mode;
    logic [63:0] s_seed_o;
    logic        s_busy, s_done, s_valid;
    logic [1:0]  s_mode_o;
    logic [4:0]  s_base_o;
    logic [1:0]  s_k, s_l, s_m;
    logic [31:0] s_rm, s_rx;
    logic [15:0] s_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    opt_rand_gen #(.CITY_NUM(30)) dut (
        .clk(clk), .reset(reset), .seed_i(seed_i), .seed_load(seed_load),
        .seed_o(seed_o), .base_id_i(base_id_i), .start(start), .mode(mode),
        .busy(busy), .done(done), .valid(valid), .mode_o(mode_o),
        .base_id_o(base_id_o), .k_o(k_o), .l_o(l_o), .m_o(m_o),
        .r_metropolis(r_metropolis), .r_exchange(r_exchange),
        .draw_cnt(draw_cnt)
    );

    opt_rand_gen #(.CITY_NUM(3)) dut_small (
        .clk(clk), .reset(reset), .seed_i(s_seed_i), .seed_load(s_seed_load),
        .seed_o(s_seed_o), .base_id_i(s_base_i), .start(s_start), .mode(s_mode),
        .busy(s_busy), .done(s_done), .valid(s_valid), .mode_o(s_mode_o),
        .base_id_o(s_base_o), .k_o(s_k), .l_o(s_l), .m_o(s_m),
        .r_metropolis(s_rm), .r_exchange(s_rx), .draw_cnt(s_cnt)
    );

    task automatic check_eq(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] xs(input logic [63:0] x);
        logic [63:0] a, b;
        a = x ^ (x << 13);
        b = a ^ (a >> 7);
        return b ^ (b << 17);
    endfunction

    // Draw distinct legal indices in sequence, then sort; then two randoms.
    task automatic model_run(input logic [63:0] st_in, input logic [1:0] md,
                             input logic [4:0] pk, pl, pm,
                             output logic [4:0] ek, el, em,
                             output logic [31:0] erm, erx,
                             output logic [63:0] st_out, output int steps);
        logic [63:0] s;
        logic [4:0]  got[3];
        logic [4:0]  c, t;
        int          need, n;
        s = st_in; steps = 0; n = 0;
        ek = pk; el = pl; em = pm;
        need = md[1] ? 0 : (md[0] ? 3 : 2);
        while (n < need) begin
            s = xs(s); steps++;
            c = s[4:0];
            if (c >= 5'd1 && c <= 5'd30 && !(n > 0 && got[0] == c)
                && !(n > 1 && got[1] == c)) begin
                got[n] = c;
                n++;
            end
        end
        for (int i = 0; i < need; i++)
            for (int j = 0; j < need - 1 - i; j++)
                if (got[j] > got[j+1]) begin
                    t = got[j]; got[j] = got[j+1]; got[j+1] = t;
                end
        if (need >= 2) begin ek = got[0]; el = got[1]; end
        if (need == 3) em = got[2];
        s = xs(s); steps++; erm = s[31:0];
        s = xs(s); steps++; erx = s[31:0];
        st_out = s;
    endtask

    logic [63:0] mdl_state;
    logic [15:0] mdl_cnt;
    logic [4:0]  mk, ml, mm;

    task automatic do_run(input logic [1:0] md, input logic [4:0] base,
                          input bit first_chk);
        logic [4:0]  ek, el, em;
        logic [31:0] erm, erx;
        logic [63:0] est;
        int          steps, lat;
        model_run(mdl_state, md, mk, ml, mm, ek, el, em, erm, erx, est, steps);
        start = 1'b1; mode = md; base_id_i = base;
        tick();
        start = 1'b0; base_id_i = ~base;
        check_eq("busy_after_start", busy, 1'b1);
        check_eq("valid_cleared", valid, 1'b0);
        lat = 0;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (first_chk && n == 1) begin
                check_eq("first_step_seed", seed_o, 64'h0000_0000_4082_2041);
                check_eq("first_step_k", k_o, 5'd1);
                check_eq("first_step_cnt", draw_cnt, 16'd1);
            end
            if (done) begin lat = n; break; end
        end
        check_eq("done_seen", done, 1'b1);
        check_eq("latency", 64'(lat), 64'(steps));
        check_eq("valid_set", valid, 1'b1);
        check_eq("k", k_o, ek);
        check_eq("l", l_o, el);
        check_eq("m", m_o, em);
        check_eq("r_metropolis", r_metropolis, erm);
        check_eq("r_exchange", r_exchange, erx);
        check_eq("seed_o", seed_o, est);
        check_eq("draw_cnt", draw_cnt, mdl_cnt + 16'(steps));
        check_eq("mode_o", mode_o, md);
        check_eq("base_id_o", base_id_o, base);
        tick();
        check_eq("done_one_cycle", done, 1'b0);
        check_eq("busy_idle", busy, 1'b0);
        check_eq("valid_held", valid, 1'b1);
        mdl_state = est; mdl_cnt = mdl_cnt + 16'(steps);
        mk = ek; ml = el; mm = em;
    endtask

    task automatic main_seq();
        reset = 1'b1; seed_i = 64'h0; seed_load = 1'b0;
        base_id_i = 5'h0A; start = 1'b0; mode = 2'b00;
        tick(); tick(); tick();
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_done", done, 1'b0);
        check_eq("rst_valid", valid, 1'b0);
        check_eq("rst_mode_o", mode_o, 2'b00);
        check_eq("rst_base", base_id_o, 5'h0A);
        check_eq("rst_klm", {k_o, l_o, m_o}, 15'h0);
        check_eq("rst_rand", {r_metropolis, r_exchange}, 64'h0);
        check_eq("rst_cnt", draw_cnt, 16'h0);
        check_eq("rst_seed_zero_fix", seed_o, 64'h1);
        reset = 1'b0;
        tick();
        mdl_state = 64'h1; mdl_cnt = 16'h0; mk = 0; ml = 0; mm = 0;

        do_run(2'b00, 5'h15, 1'b1);
        do_run(2'b01, 5'h03, 1'b0);
        do_run(2'b10, 5'h1F, 1'b0);
        do_run(2'b11, 5'h07, 1'b0);
        for (int i = 0; i < 12; i++)
            do_run(2'(i % 4), 5'(i * 7 + 3), 1'b0);

        // seed_load while results are valid
        seed_load = 1'b1; seed_i = 64'h0;
        tick();
        seed_load = 1'b0;
        check_eq("sl_valid_clear", valid, 1'b0);
        check_eq("sl_seed", seed_o, 64'h1);
        check_eq("sl_keep_rx", r_exchange, mdl_state[31:0]);

        // or-opt request, extra start while busy, abort in DRAW_L
        start = 1'b1; mode = 2'b01; base_id_i = 5'h0C;
        tick();
        mode = 2'b00; base_id_i = 5'h11;
        tick();
        check_eq("busy_start_mode", mode_o, 2'b01);
        check_eq("busy_start_base", base_id_o, 5'h0C);
        check_eq("drawk_seed", seed_o, 64'h0000_0000_4082_2041);
        check_eq("drawk_k", k_o, 5'd1);
        start = 1'b0; seed_load = 1'b1; seed_i = 64'h0123_4567_89AB_CDEF;
        tick();
        seed_load = 1'b0;
        check_eq("abort_busy", busy, 1'b0);
        check_eq("abort_valid", valid, 1'b0);
        check_eq("abort_seed", seed_o, 64'h0123_4567_89AB_CDEF);
        check_eq("abort_k_kept", k_o, 5'd1);
        check_eq("abort_l_kept", l_o, ml);
        check_eq("abort_cnt", draw_cnt, mdl_cnt + 16'd1);
        tick();
        check_eq("abort_stays_idle", busy, 1'b0);
        check_eq("abort_no_done", done, 1'b0);
        check_eq("abort_seed_frozen", seed_o, 64'h0123_4567_89AB_CDEF);
        mdl_cnt = mdl_cnt + 16'd1; mk = 5'd1;

        // seed_load and start together: start ignored
        seed_load = 1'b1; start = 1'b1; seed_i = 64'h0;
        tick();
        seed_load = 1'b0; start = 1'b0;
        check_eq("sl_start_busy", busy, 1'b0);
        check_eq("sl_start_seed", seed_o, 64'h1);
        tick();
        check_eq("sl_start_idle", busy, 1'b0);
        mdl_state = 64'h1;
        do_run(2'b01, 5'h1A, 1'b0);
        do_run(2'b00, 5'h02, 1'b0);
    endtask

    task automatic small_seq();
        int cyc, runs;
        s_seed_i = 64'hDEAD_BEEF_CAFE_F00D; s_seed_load = 1'b0;
        s_base_i = 5'h05; s_start = 1'b1; s_mode = 2'b01;
        wait (reset == 1'b0);
        cyc = 0; runs = 0;
        while (s_cnt != 16'hFFFF && cyc < 85000) begin
            tick(); cyc++;
            if (s_done) begin
                runs++;
                if (runs <= 1000) begin
                    check_eq("small_k", s_k, 2'd1);
                    check_eq("small_l", s_l, 2'd2);
                    check_eq("small_m", s_m, 2'd3);
                end
            end
        end
        check_eq("sat_reached", s_cnt, 16'hFFFF);
        for (int r = 0; r < 3; r++) begin
            tick();
            for (int n = 0; n < 200 && !s_done; n++) tick();
            check_eq("sat_done_seen", s_done, 1'b1);
            check_eq("sat_hold", s_cnt, 16'hFFFF);
            check_eq("sat_small_m", s_m, 2'd3);
        end
    endtask

    initial begin
        fork
            main_seq();
            small_seq();
        join
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
